mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences the single shared memory port between the pipeline's instruction-fetch requester and its load/store requester. Each requester issues one transaction at a time; the block grants one, drives the memory request handshake and waits for the response. It then returns read data (or a write acknowledge) to the owner and raises a stall to the core while anything is pending. It sits between the rv32i core's fetch/data ports and the unified instruction/data memory.

## Interface
- `STARVE_MAX`, 4: consecutive data grants allowed while a fetch waits before fetch is forced (range 1..15)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `i_req`  in  1  fetch request; held until `i_valid`
- `i_addr`  in  `DATA_W`  fetch byte address; word-aligned; stable while `i_req`
- `i_kill`  in  1  discard the in-flight fetch (pc redirect)
- `i_rdata`  out  `DATA_W`  fetched instruction; valid with `i_valid`
- `i_valid`  out  1  one-cycle fetch completion pulse
- `d_req`  in  1  data request; held until `d_valid`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  `DATA_W`  data byte address
- `d_wdata`  in  `DATA_W`  store data
- `d_rdata`  out  `DATA_W`  load data; valid with `d_valid`
- `d_valid`  out  1  one-cycle data completion pulse (load data or store ack)
- `m_req`  out  1  memory request
- `m_we`  out  1  memory write enable
- `m_addr`  out  `DATA_W`  memory address
- `m_wdata`  out  `DATA_W`  memory write data
- `m_gnt`  in  1  memory accepted the request this cycle
- `m_rvalid`  in  1  response (read data or write ack); earliest one cycle after `m_gnt`
- `m_rdata`  in  `DATA_W`  read data
- `stall`  out  1  `i_req | d_req | state != IDLE`; combinational

## Operation
- States: IDLE, ISSUE, WAIT, RESP. `owner` register is FETCH or DATA.
- IDLE:
  - Neither request: stay.
  - Only one request: grant it.
  - Both requests: grant DATA unless `starve_cnt == STARVE_MAX`, in which case grant FETCH.
  - On grant, latch address, we and wdata into `m_*` registers (we = 0 for fetch), set `owner` -> ISSUE.
- ISSUE: `m_req = 1`. On `m_gnt` -> WAIT. Without `m_gnt`, hold all `m_*` stable.
- WAIT: `m_req = 0`. On `m_rvalid`, latch `m_rdata` into the owner's rdata register -> RESP.
- RESP: pulse the owner's valid for one cycle -> IDLE. Requests are not sampled in RESP.
- Starvation counter (4 bits):
  - Increments on a DATA grant while `i_req` is high.
  - Clears on any FETCH grant, or on a DATA grant with `i_req` low.
  - Saturates at `STARVE_MAX`.
- Kill:
  - `i_kill` while FETCH is owner in ISSUE and `m_gnt` is low: abort and return to IDLE, no `i_valid`.
  - `i_kill` in ISSUE with `m_gnt` high, or in WAIT: set `kill_pend`. The transaction completes normally, but the RESP cycle suppresses `i_valid`. `kill_pend` clears at IDLE.
  - `i_kill` while DATA is owner or in IDLE: no effect.
- `m_rvalid` outside WAIT is ignored.
- Requester rule: drop or replace `req` in the cycle after its valid pulse. The arbiter re-samples in IDLE that cycle.

## Timing
- Reset values: state IDLE; `owner` FETCH; all `m_*`, `i_rdata`, `d_rdata`, `i_valid`, `d_valid` = 0; `starve_cnt` 0; `kill_pend` 0. `stall` = `i_req | d_req` after reset.
- Reset mid-transaction returns to IDLE in one cycle and drops all pending state. The memory shares `rst`, so no stale response follows.
- Minimum latency, request sampled in cycle 0 with immediate `m_gnt` and `m_rvalid` one cycle later:
  - `m_req` high in cycle 1
  - `m_rvalid` in cycle 2
  - valid pulse in cycle 3
  - next grant sampled in cycle 4
  - peak throughput is 1 transaction per 4 cycles
- Each `m_gnt` wait cycle adds one cycle, as does each cycle of `m_rvalid` delay.
- `*_rdata` holds its value until the next completion for the same owner.

## Structure
- `DATA_W` comes from `def.h`. Add `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP` (2-bit) and `OWN_FETCH`/`OWN_DATA` defines there.
- No sub-module: one FSM always-block, one starvation counter, the output registers and the combinational `stall`.

## Test plan
- Fetch only, `i_addr = 0x10`, `m_gnt` immediate, `m_rdata = 0x00500093` one cycle later -> `i_valid` in cycle 3 with `i_rdata = 0x00500093`; `m_we = 0`.
- `i_req` and `d_req` both high in the same cycle, data store to `0x100` with wdata `0xDEADBEEF` -> store is issued first (`m_we = 1`, `m_addr = 0x100`); `d_valid` follows, then the fetch is issued; `stall` stays high throughout.
- `d_req` held continuously and `i_req` held, `STARVE_MAX = 4` -> four data grants, then a fetch grant, then the counter restarts from 0.
- `m_gnt` withheld 3 cycles in ISSUE -> `m_req`/`m_addr`/`m_wdata` stable all 3 cycles; valid arrives 3 cycles later than the minimum.
- `i_kill` in ISSUE without `m_gnt` -> IDLE next cycle with no `i_valid`. `i_kill` in WAIT -> `m_rvalid` is consumed, no `i_valid`, and the next fetch at the new address proceeds normally.
- `rst` asserted in WAIT -> next cycle all outputs are 0 and the state is IDLE; a fresh request completes with minimum latency.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter.
//   DATA_W       : address/data width of the fetch, data and memory ports
//   CNT_W        : width of the fetch starvation counter
//   arb_state_t  : arbiter FSM state encoding
//   arb_owner_t  : which requester owns the transaction in flight
package mem_port_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between instruction fetch and load/store.
// One transaction is in flight at a time; the completion is returned to the
// requester that owned it as a one-cycle valid pulse.
//
// Ports
//   clk, rst                 : clock, synchronous active-high reset
//   i_req/i_addr/i_kill      : fetch request, address, in-flight fetch discard
//   i_rdata/i_valid          : fetch data and completion pulse
//   d_req/d_we/d_addr/d_wdata: data request (store when d_we=1)
//   d_rdata/d_valid          : load data / store ack and completion pulse
//   m_req/m_we/m_addr/m_wdata: memory request side
//   m_gnt/m_rvalid/m_rdata   : memory accept and response
//   stall                    : core stall while anything is requested/pending
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | sample requests, pick owner, latch m_* fields
// ARB_ISSUE | m_req high, m_* held until m_gnt
// ARB_WAIT  | request accepted, waiting for m_rvalid
// ARB_RESP  | owner's valid pulse; requests not sampled
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [DATA_W-1:0] i_addr,
  input  logic              i_kill,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [DATA_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_gnt,
  input  logic              m_rvalid,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              stall
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_t        state, state_nxt;
  arb_owner_t        owner, owner_nxt;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
  logic              kill_pend, kill_pend_nxt;
  logic              m_we_nxt;
  logic [DATA_W-1:0] m_addr_nxt, m_wdata_nxt;
  logic [DATA_W-1:0] i_rdata_nxt, d_rdata_nxt;
  logic              i_valid_nxt, d_valid_nxt;
  logic              grant_data;

  assign m_req = (state == ARB_ISSUE);
  assign stall = i_req | d_req | (state != ARB_IDLE);

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    starve_cnt_nxt = starve_cnt;
    kill_pend_nxt  = kill_pend;
    m_we_nxt       = m_we;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    i_valid_nxt    = 1'b0;
    d_valid_nxt    = 1'b0;
    grant_data     = 1'b0;

    case (state)
      ARB_IDLE: begin
        kill_pend_nxt = 1'b0;
        if (i_req || d_req) begin
          // Data wins ties until fetch has waited STARVE_MAX data grants.
          grant_data = d_req && !(i_req && (starve_cnt == STARVE_LIM));
          state_nxt  = ARB_ISSUE;
          if (grant_data) begin
            owner_nxt   = OWN_DATA;
            m_we_nxt    = d_we;
            m_addr_nxt  = d_addr;
            m_wdata_nxt = d_wdata;
            if (!i_req)
              starve_cnt_nxt = '0;
            else if (starve_cnt != STARVE_LIM)
              starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end else begin
            owner_nxt      = OWN_FETCH;
            m_we_nxt       = 1'b0;
            m_addr_nxt     = i_addr;
            m_wdata_nxt    = '0;
            starve_cnt_nxt = '0;
          end
        end
      end

      ARB_ISSUE: begin
        if (i_kill && (owner == OWN_FETCH)) begin
          // Once the memory has accepted, the response must still be drained.
          if (m_gnt) begin
            kill_pend_nxt = 1'b1;
            state_nxt     = ARB_WAIT;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else if (m_gnt) begin
          state_nxt = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        if (i_kill && (owner == OWN_FETCH))
          kill_pend_nxt = 1'b1;
        if (m_rvalid) begin
          state_nxt = ARB_RESP;
          if (owner == OWN_FETCH) begin
            i_rdata_nxt = m_rdata;
            i_valid_nxt = !(kill_pend || i_kill);
          end else begin
            d_rdata_nxt = m_rdata;
            d_valid_nxt = 1'b1;
          end
        end
      end

      ARB_RESP: begin
        state_nxt = ARB_IDLE;
      end

      default: begin
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_FETCH;
      starve_cnt <= '0;
      kill_pend  <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_cnt_nxt;
      kill_pend  <= kill_pend_nxt;
      m_we       <= m_we_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_valid    <= i_valid_nxt;
      d_valid    <= d_valid_nxt;
    end
  end

endmodule
